ctrl_mc: RTL and testbench
==========================

CTRL_MC -- requirements
Module: ctrl_mc

Interface
REQ-001 Parameter OPC_W, 4, opcode field width; opcode encodings zero-extended to OPC_W.
REQ-002 Parameter MM_W, 4, mode/mask field width; also status width.
REQ-003 Parameter ALU_OP_W, 2, alu_op output width (>=2).
REQ-004 Parameter IMM_MODE, MM_W'd8, mm value selecting immediate ALU operand.
REQ-005 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port opcode  input  OPC_W  current instruction opcode, stable from DECODE until FETCH.
REQ-008 Port mm  input  MM_W  mode/condition mask field.
REQ-009 Port stat  input  MM_W  ALU status flags from last ALU_OP.
REQ-010 Port dm_ack  input  1  data-memory completion, one-cycle pulse.
REQ-011 Port pc_write, ir_load, rf_we, wb_sel, rd_sel, br_sel, dm_req, dm_we, stat_en  output  1 each  datapath strobes/selects.
REQ-012 Port alu_op  output  ALU_OP_W  00 reg-reg, 01 immediate, 10 address add, 11 pass.
REQ-013 Port halted  output  1  high while in HALT.

Function
REQ-014 Opcodes SHALL be NOOP=0, LOD=1, STR=2, BRA=4, BRR=5, BNE=6, ALU_OP=8, HLT=15; others decode as NOOP.
REQ-015 States SHALL be START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
REQ-016 Transitions: START0->START1->FETCH->DECODE; DECODE->HALT if opcode==HLT else EXECUTE; EXECUTE->MEM->WRITEBACK->FETCH; HALT holds until rst.
REQ-017 All outputs SHALL be combinational from present state, opcode, mm, stat; every output 0 in START0, START1, HALT except halted=1 in HALT.
REQ-018 FETCH: ir_load=1, pc_write=1, br_sel=0 (PC+1); all other strobes 0.
REQ-019 DECODE: rd_sel=1 for STR, else 0; no writes.
REQ-020 EXECUTE, ALU_OP: alu_op=01 if mm==IMM_MODE else 00; stat_en=1.
REQ-021 EXECUTE, LOD/STR: alu_op=10; BRR: alu_op=10.
REQ-022 EXECUTE, BRA: pc_write=br_sel=1 iff (mm & stat)!=0; BNE: iff (mm & stat)==0; BRR: iff (mm & stat)!=0; mm=0 never branches for BRA/BRR, always for BNE.
REQ-023 MEM, LOD: dm_req=1; MEM, STR: dm_req=1, dm_we=1; dm_req deasserts on exit from MEM.
REQ-024 WRITEBACK: rf_we=1 for ALU_OP (wb_sel=0) and LOD (wb_sel=1); else rf_we=0.
REQ-025 NOOP and non-taken branches SHALL traverse all states with no write strobe asserted.
REQ-026 A branch updates PC exactly once (EXECUTE); FETCH of next instruction still asserts pc_write with br_sel=0 from the branch target.
REQ-027 dm_ack outside MEM SHALL be ignored.

Reset
REQ-028 rst high at a rising edge SHALL force START0 next cycle from any state, including mid-MEM stall and HALT; all outputs 0 the cycle after.
REQ-029 After rst falls, first FETCH SHALL occur on the third rising edge.

Configuration
REQ-030 Macro CTRL_MC_STALL_EN defined: MEM holds while dm_req=1 and dm_ack=0 for LOD/STR, exits to WRITEBACK on the cycle dm_ack=1 is sampled; other opcodes leave MEM after one cycle.
REQ-031 Macro CTRL_MC_STALL_EN undefined: MEM always lasts exactly one cycle; dm_ack unused.

Verification
REQ-032 rst pulse, then ALU_OP mm=0 -> FETCH at edge 3; alu_op=00 in EXECUTE, rf_we=1 wb_sel=0 only in WRITEBACK; 5 cycles per instruction.
REQ-033 ALU_OP mm=8 -> alu_op=01 in EXECUTE, stat_en=1 for exactly one cycle.
REQ-034 BRA mm=4'b0010, stat=4'b0010 -> pc_write=br_sel=1 in EXECUTE; stat=4'b0100 -> no pc_write in EXECUTE; BNE mm=0 -> taken.
REQ-035 STALL_EN, LOD, dm_ack after 3 cycles -> dm_req high 4 MEM cycles, then rf_we=1 wb_sel=1; STR same with dm_we=1, rf_we=0.
REQ-036 HLT -> halted=1 from cycle after DECODE, held 10 cycles; rst -> START0, halted=0.
REQ-037 rst asserted during MEM stall -> dm_req=0 next cycle, no rf_we pulse.

Source files
------------

// File: rtl/ctrl_mc.sv
// ctrl_mc -- multi-cycle instruction controller.
// Walks each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK
// and decodes the datapath strobes from the present state and the
// instruction fields.
// Optional feature: define CTRL_MC_STALL_EN to let MEM wait for dm_ack on
// loads and stores; without it MEM always lasts a single cycle.
module ctrl_mc #(
    parameter int               OPC_W    = 4,
    parameter int               MM_W     = 4,
    parameter int               ALU_OP_W = 2,
    parameter logic [MM_W-1:0]  IMM_MODE = MM_W'(8)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPC_W-1:0]     opcode,
    input  logic [MM_W-1:0]      mm,
    input  logic [MM_W-1:0]      stat,
    input  logic                 dm_ack,
    output logic                 pc_write,
    output logic                 ir_load,
    output logic                 rf_we,
    output logic                 wb_sel,
    output logic                 rd_sel,
    output logic                 br_sel,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic                 stat_en,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic                 halted
);

    // Opcode encodings, zero-extended to the opcode field width.
    localparam logic [OPC_W-1:0] OP_LOD = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_STR = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_BRA = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_BRR = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_BNE = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_ALU = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(15);

    // Controller states.
    localparam logic [2:0] S_START0    = 3'd0;
    localparam logic [2:0] S_START1    = 3'd1;
    localparam logic [2:0] S_FETCH     = 3'd2;
    localparam logic [2:0] S_DECODE    = 3'd3;
    localparam logic [2:0] S_EXECUTE   = 3'd4;
    localparam logic [2:0] S_MEM       = 3'd5;
    localparam logic [2:0] S_WRITEBACK = 3'd6;
    localparam logic [2:0] S_HALT      = 3'd7;

    // ALU operation codes.
    localparam logic [ALU_OP_W-1:0] ALU_RR   = ALU_OP_W'(2'b00);
    localparam logic [ALU_OP_W-1:0] ALU_IMM  = ALU_OP_W'(2'b01);
    localparam logic [ALU_OP_W-1:0] ALU_ADDR = ALU_OP_W'(2'b10);

    logic [2:0] r_state;
    logic [2:0] w_next;

    // Opcode decode; anything not listed behaves as NOOP.
    logic w_is_lod, w_is_str, w_is_bra, w_is_brr, w_is_bne, w_is_alu, w_is_hlt;
    logic w_is_mem, w_hit, w_taken;

    assign w_is_lod = (opcode == OP_LOD);
    assign w_is_str = (opcode == OP_STR);
    assign w_is_bra = (opcode == OP_BRA);
    assign w_is_brr = (opcode == OP_BRR);
    assign w_is_bne = (opcode == OP_BNE);
    assign w_is_alu = (opcode == OP_ALU);
    assign w_is_hlt = (opcode == OP_HLT);
    assign w_is_mem = w_is_lod | w_is_str;

    // A condition hits when any masked status flag is set; mm==0 never hits,
    // so BRA/BRR with mm==0 never branch and BNE with mm==0 always does.
    assign w_hit   = |(mm & stat);
    assign w_taken = ((w_is_bra | w_is_brr) & w_hit) | (w_is_bne & ~w_hit);

`ifndef CTRL_MC_STALL_EN
    // Memory completion only matters when MEM may stall.
    logic w_unused_ack;
    assign w_unused_ack = dm_ack;
`endif

    // State register; synchronous reset returns to START0 from anywhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_START0;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state sequencing.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_START0:    w_next = S_START1;
            S_START1:    w_next = S_FETCH;
            S_FETCH:     w_next = S_DECODE;
            S_DECODE: begin
                if (w_is_hlt) begin
                    w_next = S_HALT;
                end else begin
                    w_next = S_EXECUTE;
                end
            end
            S_EXECUTE:   w_next = S_MEM;
            S_MEM: begin
`ifdef CTRL_MC_STALL_EN
                // Loads/stores wait here until the memory acknowledges.
                if (w_is_mem && !dm_ack) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WRITEBACK;
                end
`else
                w_next = S_WRITEBACK;
`endif
            end
            S_WRITEBACK: w_next = S_FETCH;
            S_HALT:      w_next = S_HALT;
            default:     w_next = S_START0;
        endcase
    end

    // Datapath strobe decode from present state and instruction fields.
    always_comb begin
        pc_write = 1'b0;
        ir_load  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        rd_sel   = 1'b0;
        br_sel   = 1'b0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        stat_en  = 1'b0;
        alu_op   = ALU_RR;
        halted   = 1'b0;
        case (r_state)
            S_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE: begin
                rd_sel = w_is_str;
            end
            S_EXECUTE: begin
                if (w_is_alu) begin
                    alu_op  = (mm == IMM_MODE) ? ALU_IMM : ALU_RR;
                    stat_en = 1'b1;
                end else if (w_is_mem || w_is_brr) begin
                    alu_op = ALU_ADDR;
                end else begin
                    alu_op = ALU_RR;
                end
                pc_write = w_taken;
                br_sel   = w_taken;
            end
            S_MEM: begin
                dm_req = w_is_mem;
                dm_we  = w_is_str;
            end
            S_WRITEBACK: begin
                rf_we  = w_is_alu | w_is_lod;
                wb_sel = w_is_lod;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_mc.sv
// tb_ctrl_mc -- self-checking bench for ctrl_mc.
// Builds the expected per-cycle strobe trace of each instruction from the
// opcode semantics and compares it against the controller every cycle.
module tb_ctrl_mc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic [3:0] mm = 4'd0;
    logic [3:0] stat = 4'd0;
    logic       dm_ack = 1'b0;
    logic       pc_write, ir_load, rf_we, wb_sel, rd_sel, br_sel;
    logic       dm_req, dm_we, stat_en, halted;
    logic [1:0] alu_op;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [11:0] exp;
        logic        ack;
    } cyc_t;

    cyc_t trace_q[$];

    ctrl_mc dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mm(mm), .stat(stat),
        .dm_ack(dm_ack), .pc_write(pc_write), .ir_load(ir_load),
        .rf_we(rf_we), .wb_sel(wb_sel), .rd_sel(rd_sel), .br_sel(br_sel),
        .dm_req(dm_req), .dm_we(dm_we), .stat_en(stat_en),
        .alu_op(alu_op), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] observed();
        return {pc_write, ir_load, rf_we, wb_sel, rd_sel, br_sel,
                dm_req, dm_we, stat_en, alu_op, halted};
    endfunction

    // Field order: pc_write ir_load rf_we wb_sel rd_sel br_sel dm_req dm_we stat_en alu_op halted
    function automatic logic [11:0] mk(bit pcw, bit irl, bit rfw, bit wbs, bit rds,
                                       bit brs, bit dmr, bit dmw, bit sen,
                                       logic [1:0] alu, bit hlt);
        return {pcw, irl, rfw, wbs, rds, brs, dmr, dmw, sen, alu, hlt};
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    function automatic bit rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction starting at FETCH.
    task automatic build(input logic [3:0] opc, input logic [3:0] m, input logic [3:0] s,
                         input int delay);
        bit         hit, taken, is_mem;
        logic [1:0] alu;
        int         mem_cycles;
        trace_q.delete();
        hit    = ((m & s) != 4'd0);
        is_mem = (opc == 4'd1) || (opc == 4'd2);
        trace_q.push_back('{mk(1,1,0,0,0,0,0,0,0,2'b00,0), rnd_bit()});
        trace_q.push_back('{mk(0,0,0,0,(opc == 4'd2),0,0,0,0,2'b00,0), rnd_bit()});
        if (opc == 4'd15) begin
            for (int k = 0; k < 10; k++)
                trace_q.push_back('{mk(0,0,0,0,0,0,0,0,0,2'b00,1), rnd_bit()});
            return;
        end
        taken = ((opc == 4'd4 || opc == 4'd5) && hit) || (opc == 4'd6 && !hit);
        alu   = 2'b00;
        if (opc == 4'd8)                    alu = (m == 4'd8) ? 2'b01 : 2'b00;
        else if (is_mem || opc == 4'd5)     alu = 2'b10;
        trace_q.push_back('{mk(taken,0,0,0,0,taken,0,0,(opc == 4'd8),alu,0), rnd_bit()});
`ifdef CTRL_MC_STALL_EN
        mem_cycles = is_mem ? delay + 1 : 1;
        for (int k = 0; k < mem_cycles; k++)
            trace_q.push_back('{mk(0,0,0,0,0,0,is_mem,(opc == 4'd2),0,2'b00,0),
                                is_mem ? (k == delay) : rnd_bit()});
`else
        mem_cycles = delay;
        trace_q.push_back('{mk(0,0,0,0,0,0,is_mem,(opc == 4'd2),0,2'b00,0), rnd_bit()});
`endif
        trace_q.push_back('{mk(0,0,(opc == 4'd8 || opc == 4'd1),(opc == 4'd1),0,0,0,0,0,2'b00,0),
                            rnd_bit()});
    endtask

    // Reset pulse followed by START0/START1; returns sampling inside FETCH.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        dm_ack = rnd_bit();
        #1;
        check("start0", observed(), 12'd0);
        @(posedge clk); #1;
        check("start1", observed(), 12'd0);
        @(posedge clk); #1;
    endtask

    // Plays one instruction; abort_at >= 0 asserts reset after that cycle.
    task automatic run(input string tag, input logic [3:0] opc, input logic [3:0] m,
                       input logic [3:0] s, input int delay, input int abort_at);
        opcode = opc;
        mm     = m;
        stat   = s;
        build(opc, m, s, delay);
        for (int i = 0; i < trace_q.size(); i++) begin
            dm_ack = trace_q[i].ack;
            #1;
            check($sformatf("%s_c%0d", tag, i), observed(), trace_q[i].exp);
            if (i == abort_at) begin
                do_reset();
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int dly;
        logic [3:0] ops [9];
        ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2; ops[3] = 4'd4; ops[4] = 4'd5;
        ops[5] = 4'd6; ops[6] = 4'd8; ops[7] = 4'd3; ops[8] = 4'd11;

        @(posedge clk); #1;
        do_reset();
        run("alu_rr",   4'd8, 4'd0, 4'd5, 0, -1);
        run("alu_imm",  4'd8, 4'd8, 4'd1, 0, -1);
        run("bra_tk",   4'd4, 4'b0010, 4'b0010, 0, -1);
        run("bra_nt",   4'd4, 4'b0010, 4'b0100, 0, -1);
        run("bne_mm0",  4'd6, 4'd0, 4'hF, 0, -1);
        run("brr_mm0",  4'd5, 4'd0, 4'hF, 0, -1);
        run("lod",      4'd1, 4'd3, 4'd0, 3, -1);
        run("str",      4'd2, 4'd3, 4'd0, 3, -1);
        run("noop",     4'd0, 4'hF, 4'hF, 0, -1);

        for (int n = 0; n < 40; n++) begin
`ifdef CTRL_MC_STALL_EN
            dly = $urandom_range(0, 4);
`else
            dly = 0;
`endif
            run($sformatf("rnd%0d", n), ops[$urandom_range(0, 8)],
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), dly, -1);
        end

        // Reset while in MEM of a load (index 3 is the first MEM cycle).
        run("lod_abort", 4'd1, 4'd0, 4'd0, 4, 3);
        run("after_abort", 4'd8, 4'd8, 4'd0, 0, -1);

        run("hlt", 4'd15, 4'd0, 4'd0, 0, -1);
        do_reset();
        run("after_hlt", 4'd1, 4'd0, 4'd0, 1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
